// File: rtl/spi_tx_queue_pkg.sv
// Shared SPI definitions: entry/status layouts and transmit FSM encodings.
// Also used by the SPI output driver, so encodings must stay stable.
package spi_tx_queue_pkg;

  localparam int unsigned ENTRY_W  = 10;
  localparam int unsigned STATUS_W = 32;
  localparam int unsigned COUNT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_GAP       = 3'd4
  } tx_state_e;

  // One queued SPI entry as written by the CPU.
  typedef struct packed {
    logic       pwr_on;
    logic       dc;
    logic [7:0] data;
  } tx_entry_t;

  // CPU-visible status word; field order fixes the bit positions.
  typedef struct packed {
    logic [21:0]        rsvd;
    logic               err;
    logic               ovf;
    logic               idle;
    logic               empty;
    logic               full;
    logic [COUNT_W-1:0] count;
  } status_t;

endpackage

// File: rtl/spi_tx_queue_if.sv
// CPU write/status port and SPI driver handshake for the transmit queue.
interface spi_tx_queue_if;
  import spi_tx_queue_pkg::*;

  logic                wr;
  logic [ENTRY_W-1:0]  wdata;
  logic                rd;
  logic [STATUS_W-1:0] status;
  logic                spi_start;
  logic [ENTRY_W-1:0]  spi_din;
  logic                spi_cs_n;

  modport master (
    output wr, wdata, rd, spi_cs_n,
    input  status, spi_start, spi_din
  );

  modport slave (
    input  wr, wdata, rd, spi_cs_n,
    output status, spi_start, spi_din
  );

endinterface

// File: rtl/spi_tx_queue_fifo_sync.sv
// Synchronous FIFO with registered pointers/occupancy and a combinational head.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module spi_tx_queue_fifo_sync #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_c_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, empty, push_ok, pop_ok;

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    pop_ok   = pop_i && !empty;
    push_ok  = push_i && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign count_o  = cnt_q;

endmodule

// File: rtl/spi_tx_queue.sv
// CPU-to-SPI transmit queue: buffers entries and hands them one at a time to the
// SPI output driver, tracking the driver's chip-select to pace transfers.
module spi_tx_queue
  import spi_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned LOW_TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           reset_,
  spi_tx_queue_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(LOW_TIMEOUT + 1);

  tx_state_e         state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  tx_entry_t         din_q, din_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              pop, timeout, drop, full, empty;
  logic [ENTRY_W-1:0] head_raw;
  tx_entry_t         head;
  logic [CW-1:0]     fifo_count;
  status_t           st;

  spi_tx_queue_fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset_   (reset_),
    .push_i   (bus.wr),
    .wdata_i  (bus.wdata),
    .pop_i    (pop),
    .head_c_o (head_raw),
    .count_o  (fifo_count)
  );

  assign head  = tx_entry_t'(head_raw);
  assign full  = (fifo_count == CW'(DEPTH));
  assign empty = (fifo_count == '0);

  // Transmit sequencer: next state, pop request and timeout bookkeeping.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    din_d   = din_q;
    pop     = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          din_d   = head;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        // Power-on commands never assert chip-select, so skip the cs_n handshake
        state_d = din_q.pwr_on ? ST_GAP : ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!bus.spi_cs_n) begin
          tmo_d   = '0;
          state_d = ST_WAIT_HIGH;
        end else if (tmo_q == TW'(LOW_TIMEOUT - 1)) begin
          timeout = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (bus.spi_cs_n) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky flags: a new event in the same cycle as a status read survives it.
  always_comb begin
    drop  = bus.wr && full && !pop;
    ovf_d = drop    | (ovf_q & ~bus.rd);
    err_d = timeout | (err_q & ~bus.rd);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      din_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      din_q   <= din_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    st       = '0;
    st.err   = err_q;
    st.ovf   = ovf_q;
    st.idle  = (state_q == ST_IDLE) && empty;
    st.empty = empty;
    st.full  = full;
    st.count = COUNT_W'(fifo_count);
  end

  assign bus.status    = st;
  assign bus.spi_start = (state_q == ST_ISSUE);
  assign bus.spi_din   = din_q;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue: cycle table for the basic handshakes, then
// hand-written sequences for long cs_n pulses, overflow/wrap, timeout and reset.
module tb_spi_tx_queue;
  import spi_tx_queue_pkg::*;

  localparam int unsigned DEPTH       = 16;
  localparam int unsigned LOW_TIMEOUT = 8;
  localparam int unsigned NVEC        = 22;

  typedef enum int {DRV_MANUAL, DRV_AUTO, DRV_NEVER} drv_mode_e;

  typedef struct {
    logic        wr;
    logic [9:0]  wdata;
    logic        rd;
    logic        cs_n;
    logic        exp_start;
    logic [9:0]  exp_din;
    logic [31:0] exp_status;
  } vec_t;

  logic      clk    = 1'b0;
  logic      reset_ = 1'b0;
  drv_mode_e drv_mode  = DRV_MANUAL;
  logic      cs_manual = 1'b1;
  int        auto_low  = 3;
  int        checks    = 0;
  int        failures  = 0;
  logic [9:0] issued[$];
  logic [9:0] expq[$];
  logic       prev_start = 1'b0;
  vec_t       tbl[NVEC];

  spi_tx_queue_if bus();

  spi_tx_queue #(
    .DEPTH       (DEPTH),
    .LOW_TIMEOUT (LOW_TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  initial forever #8 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver model: cs_n changes on the falling edge, sampled by the DUT on the rising one.
  initial begin
    int cnt;
    cnt = 0;
    bus.spi_cs_n = 1'b1;
    forever begin
      @(negedge clk);
      case (drv_mode)
        DRV_MANUAL: begin
          bus.spi_cs_n = cs_manual;
          cnt = 0;
        end
        DRV_NEVER: bus.spi_cs_n = 1'b1;
        DRV_AUTO: begin
          if (cnt > 0) begin
            bus.spi_cs_n = 1'b0;
            cnt--;
          end else begin
            bus.spi_cs_n = 1'b1;
          end
          if (bus.spi_start && !bus.spi_din[9]) cnt = auto_low;
        end
        default: bus.spi_cs_n = 1'b1;
      endcase
    end
  end

  // Monitor: record every issued entry and reject back-to-back start pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_ === 1'b1 && bus.spi_start === 1'b1) begin
        issued.push_back(bus.spi_din);
        checks++;
        if (prev_start) begin
          failures++;
          $display("FAIL start_pulse_width: spi_start high two cycles in a row, din=0x%0h", bus.spi_din);
        end
      end
      prev_start = bus.spi_start;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_    = 1'b0;
    bus.wr    = 1'b0;
    bus.wdata = '0;
    bus.rd    = 1'b0;
    drv_mode  = DRV_MANUAL;
    cs_manual = 1'b1;
    tick();
    tick();
    chk("reset_status", bus.status, 32'h0C0);
    chk("reset_start", 32'(bus.spi_start), 32'h0);
    chk("reset_din", 32'(bus.spi_din), 32'h0);
    tick();
    reset_ = 1'b1;
    issued.delete();
  endtask

  initial begin
    logic saw;
    int   budget;

    //         wr    wdata    rd    cs_n  start din      status
    tbl[0]  = '{1'b1, 10'h0AF, 1'b0, 1'b1, 1'b0, 10'h000, 32'h0C0};
    tbl[1]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 32'h001};
    tbl[2]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h0AF, 32'h040};
    tbl[3]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h0AF, 32'h040};
    tbl[4]  = '{1'b1, 10'h012, 1'b0, 1'b0, 1'b0, 10'h0AF, 32'h040};
    tbl[5]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h0AF, 32'h001};
    tbl[6]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h0AF, 32'h001};
    tbl[7]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h0AF, 32'h001};
    tbl[8]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h0AF, 32'h001};
    tbl[9]  = '{1'b1, 10'h200, 1'b0, 1'b1, 1'b1, 10'h012, 32'h040};
    tbl[10] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h012, 32'h001};
    tbl[11] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h012, 32'h001};
    tbl[12] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h012, 32'h001};
    tbl[13] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h012, 32'h001};
    tbl[14] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h200, 32'h040};
    tbl[15] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h200, 32'h040};
    tbl[16] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h200, 32'h0C0};
    tbl[17] = '{1'b1, 10'h3C3, 1'b0, 1'b1, 1'b0, 10'h200, 32'h0C0};
    tbl[18] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h200, 32'h001};
    tbl[19] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h3C3, 32'h040};
    tbl[20] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h3C3, 32'h040};
    tbl[21] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h3C3, 32'h0C0};

    do_reset();
    for (int i = 0; i < int'(NVEC); i++) begin
      bus.wr    = tbl[i].wr;
      bus.wdata = tbl[i].wdata;
      bus.rd    = tbl[i].rd;
      cs_manual = tbl[i].cs_n;
      chk($sformatf("tbl%0d_start", i), 32'(bus.spi_start), 32'(tbl[i].exp_start));
      chk($sformatf("tbl%0d_din", i), 32'(bus.spi_din), 32'(tbl[i].exp_din));
      chk($sformatf("tbl%0d_status", i), bus.status, tbl[i].exp_status);
      tick();
    end
    bus.wr = 1'b0;
    bus.rd = 1'b0;

    // 400-cycle chip-select pulse; the queued entry waits for cs_n high plus GAP.
    do_reset();
    bus.wr = 1'b1; bus.wdata = 10'h0AF; tick();
    bus.wdata = 10'h0B0; tick();
    bus.wr = 1'b0;
    chk("a_start_latency", 32'(bus.spi_start), 32'h1);
    chk("a_din", 32'(bus.spi_din), 32'h0AF);
    tick();
    cs_manual = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.spi_start) saw = 1'b1;
      tick();
    end
    chk("a_no_start_while_low", 32'(saw), 32'h0);
    chk("a_status_wait_high", bus.status, 32'h001);
    cs_manual = 1'b1;
    tick();
    chk("a_gap_no_start", 32'(bus.spi_start), 32'h0);
    tick();
    chk("a_idle_no_start", 32'(bus.spi_start), 32'h0);
    tick();
    chk("a_second_start", 32'(bus.spi_start), 32'h1);
    chk("a_second_din", 32'(bus.spi_din), 32'h0B0);

    // Overflow with stalled driver, rd clearing, push+pop at full, wrap-around drain.
    do_reset();
    cs_manual = 1'b0;
    bus.wr = 1'b1; bus.wdata = 10'h0FF; tick();
    bus.wr = 1'b0;
    tick();
    chk("b_first_start", 32'(bus.spi_start), 32'h1);
    tick();
    tick();
    for (int i = 0; i < 17; i++) begin
      bus.wr = 1'b1;
      bus.wdata = 10'h100 + 10'(i);
      tick();
    end
    bus.wr = 1'b0;
    chk("b_full_ovf", bus.status, 32'h130);
    bus.rd = 1'b1; tick();
    bus.rd = 1'b0;
    chk("b_rd_clears_ovf", bus.status, 32'h030);
    bus.wr = 1'b1; bus.wdata = 10'h3FF; bus.rd = 1'b1; tick();
    bus.wr = 1'b0; bus.rd = 1'b0;
    chk("b_set_wins_over_rd", bus.status, 32'h130);
    bus.rd = 1'b1; tick();
    bus.rd = 1'b0;
    chk("b_rd_clears_again", bus.status, 32'h030);
    cs_manual = 1'b1;
    tick();
    chk("b_gap_full", bus.status, 32'h030);
    tick();
    chk("b_idle_full", bus.status, 32'h030);
    drv_mode = DRV_AUTO;
    auto_low = 3;
    bus.wr = 1'b1; bus.wdata = 10'h111; tick();
    bus.wr = 1'b0;
    chk("b_push_pop_at_full", bus.status, 32'h030);
    chk("b_issue_head", 32'(bus.spi_din), 32'h100);
    for (int v = 'h112; v <= 'h128; v++) begin
      budget = 0;
      while (bus.status[5] && budget < 200) begin
        tick();
        budget++;
      end
      if (budget >= 200) chk("b_wait_space_timeout", 32'h0, 32'h1);
      bus.wr = 1'b1;
      bus.wdata = 10'(v);
      tick();
      bus.wr = 1'b0;
    end
    budget = 0;
    while (!bus.status[7] && budget < 3000) begin
      tick();
      budget++;
    end
    chk("b_drained_idle", 32'(bus.status[7]), 32'h1);
    expq.delete();
    expq.push_back(10'h0FF);
    for (int i = 'h100; i <= 'h10F; i++) expq.push_back(10'(i));
    for (int i = 'h111; i <= 'h128; i++) expq.push_back(10'(i));
    chk("b_issue_count", 32'(issued.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < issued.size(); i++)
      chk($sformatf("b_issue%0d", i), 32'(issued[i]), 32'(expq[i]));

    // Driver never lowers cs_n: timeout sets err, next entry still goes out.
    do_reset();
    drv_mode = DRV_NEVER;
    bus.wr = 1'b1; bus.wdata = 10'h055; tick();
    bus.wdata = 10'h066; tick();
    bus.wr = 1'b0;
    chk("c_start", 32'(bus.spi_start), 32'h1);
    chk("c_din", 32'(bus.spi_din), 32'h055);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.spi_start) saw = 1'b1;
    end
    chk("c_no_start_wait_low", 32'(saw), 32'h0);
    chk("c_last_wait_low", bus.status, 32'h001);
    tick();
    chk("c_err_set", bus.status, 32'h201);
    chk("c_idle_no_start", 32'(bus.spi_start), 32'h0);
    tick();
    chk("c_next_start", 32'(bus.spi_start), 32'h1);
    chk("c_next_din", 32'(bus.spi_din), 32'h066);
    chk("c_err_sticky", bus.status, 32'h240);
    bus.rd = 1'b1; tick();
    bus.rd = 1'b0;
    chk("c_rd_clears_err", bus.status, 32'h040);

    // Reset during WAIT_HIGH with entries queued.
    do_reset();
    cs_manual = 1'b0;
    bus.wr = 1'b1; bus.wdata = 10'h0AA; tick();
    bus.wr = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      bus.wr = 1'b1;
      bus.wdata = 10'h040 + 10'(i);
      tick();
    end
    bus.wr = 1'b0;
    chk("d_queued", bus.status, 32'h005);
    chk("d_din_held", 32'(bus.spi_din), 32'h0AA);
    reset_ = 1'b0;
    #2;
    chk("d_async_status", bus.status, 32'h0C0);
    chk("d_async_start", 32'(bus.spi_start), 32'h0);
    chk("d_async_din", 32'(bus.spi_din), 32'h0);
    tick(); tick(); tick();
    reset_ = 1'b1;
    cs_manual = 1'b1;
    issued.delete();
    for (int i = 0; i < 30; i++) tick();
    chk("d_no_start_after_reset", 32'(issued.size()), 32'h0);
    chk("d_status_after_reset", bus.status, 32'h0C0);
    bus.wr = 1'b1; bus.wdata = 10'h077; tick();
    bus.wr = 1'b0;
    tick();
    chk("d_recover_start", 32'(bus.spi_start), 32'h1);
    chk("d_recover_din", 32'(bus.spi_din), 32'h077);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
